// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and default geometry for the systolic-array sequencer
package sa_pkg;
  localparam int SA_WIDTH = 16;
  localparam int SA_N = 4;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, FIN} sa_state_e;
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage data+valid shift register; data is zeroed whenever valid is low
module skew_line #(
  parameter int W = 16,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_valid = i_valid;
    assign o_data = i_valid ? i_data : '0;
  end else begin : g_shift
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0][W-1:0] r_d;
    // shift valid and masked data one stage per cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= '0;
        r_d <= '0;
      end else begin
        r_v[0] <= i_valid;
        r_d[0] <= i_valid ? i_data : '0;
        for (int k = 1; k < DEPTH; k++) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
    end
    assign o_valid = r_v[DEPTH-1];
    assign o_data = r_d[DEPTH-1];
  end
endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: loads weights, streams skewed activation rows into an NxN array and deskews results
module sa_sequencer import sa_pkg::*; #(
  parameter int WIDTH = SA_WIDTH,
  parameter int N = SA_N,
  parameter int ARR_LAT = N,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic                 w_load,
  output logic [$clog2(N)-1:0] w_row,
  output logic                 act_rd_en,
  output logic [LEN_W-1:0]     act_rd_addr,
  input  logic [N*WIDTH-1:0]   act_data,
  output logic [N*WIDTH-1:0]   arr_in_up,
  output logic [N-1:0]         arr_enable,
  input  logic [N*WIDTH-1:0]   arr_out,
  input  logic                 ovf_in,
  output logic                 res_valid,
  output logic [LEN_W-1:0]     res_addr,
  output logic [N*WIDTH-1:0]   res_data,
  output logic                 ovf_flag
);
  localparam int RW = $clog2(N);
  localparam int VP = N + ARR_LAT;
  sa_state_e r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_res_cnt;
  logic [VP-1:0] r_vp;
  logic [N-1:0] w_dsk_v;
  // job control FSM with registered strobes; r_res_cnt tracks rows already delivered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len <= '0;
      r_res_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      w_load <= 1'b0;
      w_row <= '0;
      act_rd_en <= 1'b0;
      act_rd_addr <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (res_valid) r_res_cnt <= r_res_cnt + LEN_W'(1);
      if (ovf_in && busy) ovf_flag <= 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_len <= len;
          r_res_cnt <= '0;
          ovf_flag <= 1'b0;
          busy <= 1'b1;
          r_state <= (len != '0) ? LOAD : FIN;
          w_load <= len != '0;
          w_row <= '0;
          done <= len == '0;
        end
        LOAD: if (w_row == RW'(N-1)) begin
          r_state <= STREAM;
          w_load <= 1'b0;
          w_row <= '0;
          act_rd_en <= 1'b1;
          act_rd_addr <= '0;
        end else begin
          w_row <= w_row + RW'(1);
        end
        STREAM: if (act_rd_addr == r_len - LEN_W'(1)) begin
          r_state <= DRAIN;
          act_rd_en <= 1'b0;
          act_rd_addr <= '0;
        end else begin
          act_rd_addr <= act_rd_addr + LEN_W'(1);
        end
        DRAIN: if (res_valid && r_res_cnt == r_len - LEN_W'(1)) begin
          r_state <= FIN;
          done <= 1'b1;
        end
        FIN: begin
          r_state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // r_vp[k] marks a row whose read was issued k+1 cycles ago; bit 0 aligns with act_data
  always_ff @(posedge clk) begin
    if (rst) r_vp <= '0;
    else r_vp <= {r_vp[VP-2:0], act_rd_en};
  end
  for (genvar j = 0; j < N; j++) begin : g_lane
    skew_line #(.W(WIDTH), .DEPTH(j)) u_skew (
      .clk(clk),
      .rst(rst),
      .i_valid(r_vp[0]),
      .i_data(act_data[j*WIDTH +: WIDTH]),
      .o_valid(arr_enable[j]),
      .o_data(arr_in_up[j*WIDTH +: WIDTH])
    );
    skew_line #(.W(WIDTH), .DEPTH(N-1-j)) u_deskew (
      .clk(clk),
      .rst(rst),
      .i_valid(r_vp[j+ARR_LAT]),
      .i_data(arr_out[j*WIDTH +: WIDTH]),
      .o_valid(w_dsk_v[j]),
      .o_data(res_data[j*WIDTH +: WIDTH])
    );
  end
  assign res_valid = &w_dsk_v;
  assign res_addr = res_valid ? r_res_cnt : '0;
endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: directed cycle-by-cycle checks of the sequencer against hand-derived timing
module tb_sa_sequencer;
  localparam int W = 16;
  localparam int N = 4;
  localparam int AL = 4;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic rst, start, ovf_in;
  logic [LW-1:0] len;
  logic busy, done, w_load, act_rd_en, res_valid, ovf_flag;
  logic [1:0] w_row;
  logic [LW-1:0] act_rd_addr, res_addr;
  logic [N*W-1:0] act_data = '0;
  logic [N*W-1:0] arr_in_up, arr_out, res_data;
  logic [N-1:0] arr_enable;
  logic [N*W-1:0] pipe [AL];
  int n_chk = 0;
  int n_fail = 0;

  sa_sequencer #(.WIDTH(W), .N(N), .ARR_LAT(AL), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .w_load(w_load), .w_row(w_row), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .act_data(act_data), .arr_in_up(arr_in_up), .arr_enable(arr_enable), .arr_out(arr_out),
    .ovf_in(ovf_in), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] row_of(int a);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = 16'(j + 1 + 16 * a);
    return r;
  endfunction

  always @(posedge clk) if (act_rd_en) act_data <= row_of(int'(act_rd_addr));

  always @(posedge clk) begin
    pipe[0] <= arr_in_up;
    for (int k = 1; k < AL; k++) pipe[k] <= pipe[k-1];
  end
  assign arr_out = pipe[AL-1];

  task automatic chk(input string tag, input int c, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
    end
  endtask

  task automatic run_job(input int m, input bit noise, input bit ovf, input int abort_c);
    int last, dc;
    bit live, g, e_wl, e_rd, e_rv;
    logic [N-1:0] e_en;
    logic [N*W-1:0] e_in, e_res;
    last = abort_c > 0 ? 20 : (m == 0 ? 3 : 15 + m);
    dc = m == 0 ? 1 : 13 + m;
    @(negedge clk);
    start = 1'b1;
    len = LW'(m);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      live = abort_c == 0 || c <= abort_c;
      g = live && m > 0;
      e_wl = g && c <= 4;
      e_rd = g && c >= 5 && c <= 4 + m;
      e_rv = g && c >= 13 && c <= 12 + m;
      e_en = '0;
      e_in = '0;
      for (int j = 0; j < N; j++) begin
        e_en[j] = g && c >= 6 + j && c <= 5 + m + j;
        e_in[j*W +: W] = e_en[j] ? 16'(j + 1 + 16 * (c - 6 - j)) : 16'd0;
      end
      e_res = e_rv ? row_of(c - 13) : '0;
      chk("w_load", c, 64'(w_load), 64'(e_wl));
      chk("w_row", c, 64'(w_row), e_wl ? 64'(c - 1) : 64'd0);
      chk("act_rd_en", c, 64'(act_rd_en), 64'(e_rd));
      chk("act_rd_addr", c, 64'(act_rd_addr), e_rd ? 64'(c - 5) : 64'd0);
      chk("arr_enable", c, 64'(arr_enable), 64'(e_en));
      chk("arr_in_up", c, 64'(arr_in_up), 64'(e_in));
      chk("res_valid", c, 64'(res_valid), 64'(e_rv));
      chk("res_addr", c, 64'(res_addr), e_rv ? 64'(c - 13) : 64'd0);
      chk("res_data", c, 64'(res_data), 64'(e_res));
      chk("done", c, 64'(done), 64'(live && c == dc));
      chk("busy", c, 64'(busy), 64'(live && c <= dc));
      chk("ovf_flag", c, 64'(ovf_flag), 64'(live && ovf && c >= 9));
      start = noise && (c == 6 || c == dc);
      len = (noise && c >= 6) ? 8'd7 : LW'(m);
      ovf_in = ovf && c == 8;
      rst = abort_c > 0 && c == abort_c;
    end
    start = 1'b0;
    ovf_in = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    len = 8'd3;
    ovf_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, 64'(busy), 64'd0);
    chk("rst_done", 0, 64'(done), 64'd0);
    chk("rst_w_load", 0, 64'(w_load), 64'd0);
    chk("rst_act_rd_en", 0, 64'(act_rd_en), 64'd0);
    chk("rst_arr_enable", 0, 64'(arr_enable), 64'd0);
    chk("rst_arr_in_up", 0, 64'(arr_in_up), 64'd0);
    chk("rst_res_valid", 0, 64'(res_valid), 64'd0);
    chk("rst_res_data", 0, 64'(res_data), 64'd0);
    chk("rst_ovf_flag", 0, 64'(ovf_flag), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 0, 64'(busy), 64'd0);
    chk("post_rst_w_load", 0, 64'(w_load), 64'd0);
    run_job(3, 1'b0, 1'b1, 0);
    run_job(0, 1'b0, 1'b0, 0);
    @(negedge clk);
    ovf_in = 1'b1;
    @(negedge clk);
    ovf_in = 1'b0;
    chk("idle_ovf_ignored", 0, 64'(ovf_flag), 64'd0);
    run_job(2, 1'b1, 1'b0, 0);
    run_job(3, 1'b0, 1'b0, 6);
    run_job(1, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
